// File: rtl/superscalar_ibuf_pkg.sv
// Shared types and lane-count helpers for the superscalar instruction buffer.
package superscalar_pkg;

  localparam int unsigned WIDTH = 32;

  typedef logic [WIDTH-1:0] instr_t;

  typedef struct packed {
    instr_t instr;
    instr_t pc;
  } ibuf_entry_t;

  function automatic int unsigned lane_min(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  // Bits needed to hold a count in 0..n
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/superscalar_ibuf_if.sv
// Fetch/issue handshake bundle of the instruction buffer.
interface superscalar_ibuf_if
  import superscalar_pkg::*;
#(
  parameter int unsigned NIN   = 4,
  parameter int unsigned NOUT  = 4,
  parameter int unsigned DEPTH = 16
) ();

  localparam int unsigned IW = cnt_width(NIN);
  localparam int unsigned OW = cnt_width(NOUT);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic                  flush;
  logic [IW-1:0]         in_cnt;
  logic [NIN*WIDTH-1:0]  in_instr;
  logic [NIN*WIDTH-1:0]  in_pc;
  logic                  in_ready;
  logic [OW-1:0]         out_avail;
  logic [NOUT*WIDTH-1:0] out_instr;
  logic [NOUT*WIDTH-1:0] out_pc;
  logic [OW-1:0]         out_take;
  logic [CW-1:0]         count;

  modport master (
    output flush, in_cnt, in_instr, in_pc, out_take,
    input  in_ready, out_avail, out_instr, out_pc, count
  );

  modport slave (
    input  flush, in_cnt, in_instr, in_pc, out_take,
    output in_ready, out_avail, out_instr, out_pc, count
  );

endinterface

// File: rtl/superscalar_ibuf_lane_rotator.sv
// Maps issue lanes to storage slots from head and fetch lanes to slots from tail.
module ibuf_lane_rotator #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned NIN   = 4,
  parameter  int unsigned NOUT  = 4,
  localparam int unsigned PW    = $clog2(DEPTH)
) (
  input  logic [PW-1:0] head,
  input  logic [PW-1:0] tail,
  output logic [PW-1:0] rd_idx [NOUT],
  output logic [PW-1:0] wr_idx [NIN]
);

  // Pointer arithmetic wraps naturally because DEPTH is a power of two
  always_comb begin
    for (int unsigned k = 0; k < NOUT; k++) rd_idx[k] = head + PW'(k);
    for (int unsigned k = 0; k < NIN; k++)  wr_idx[k] = tail + PW'(k);
  end

endmodule

// File: rtl/superscalar_ibuf.sv
// Multi-lane in-order instruction FIFO between fetch and issue with whole-buffer flush.
// Optional same-cycle fetch-to-issue bypass when empty: define IBUF_BYPASS_EN.
module superscalar_ibuf
  import superscalar_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned NIN   = 4,
  parameter int unsigned NOUT  = 4
) (
  input logic               CLK,
  input logic               CLR,
  superscalar_ibuf_if.slave bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned OW = cnt_width(NOUT);

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count_q;
  ibuf_entry_t   mem [DEPTH];

  logic [PW-1:0] rd_idx  [NOUT];
  logic [PW-1:0] wr_idx  [NIN];
  ibuf_entry_t   in_e    [NIN];
  ibuf_entry_t   wr_data [NIN];
  ibuf_entry_t   out_e   [NOUT];

  int unsigned in_n, enq_n, avail, take, skip, store_n, head_adv;
  logic        ready, bypass;

  ibuf_lane_rotator #(.DEPTH(DEPTH), .NIN(NIN), .NOUT(NOUT)) u_rot (
    .head   (head),
    .tail   (tail),
    .rd_idx (rd_idx),
    .wr_idx (wr_idx)
  );

  always_comb begin
    for (int unsigned k = 0; k < NIN; k++) begin
      in_e[k].instr = bus.in_instr[k*WIDTH +: WIDTH];
      in_e[k].pc    = bus.in_pc[k*WIDTH +: WIDTH];
    end
  end

  // Lane accounting: clamp, all-or-nothing enqueue, bounded take
  always_comb begin
    in_n  = lane_min(32'(bus.in_cnt), NIN);
    ready = (DEPTH - 32'(count_q)) >= NIN;
    enq_n = (ready && in_n != 0) ? in_n : 0;
`ifdef IBUF_BYPASS_EN
    bypass = (count_q == '0) && !bus.flush;
`else
    bypass = 1'b0;
`endif
    avail    = bypass ? lane_min(in_n, NOUT) : lane_min(32'(count_q), NOUT);
    take     = lane_min(32'(bus.out_take), avail);
    // Bypassed lanes already issued are never written; head only moves over stored entries
    skip     = bypass ? take : 0;
    store_n  = enq_n - skip;
    head_adv = bypass ? 0 : take;
  end

  always_comb begin
    for (int unsigned j = 0; j < NIN; j++) begin
      wr_data[j] = '0;
      for (int unsigned i = 0; i < NIN; i++) begin
        if (i == j + skip) wr_data[j] = in_e[i];
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NOUT; k++) begin
      out_e[k] = '0;
      if (k < avail) begin
        if (bypass && k < NIN) out_e[k] = in_e[k];
        else                   out_e[k] = mem[rd_idx[k]];
      end
    end
  end

  always_comb begin
    bus.out_instr = '0;
    bus.out_pc    = '0;
    for (int unsigned k = 0; k < NOUT; k++) begin
      bus.out_instr[k*WIDTH +: WIDTH] = out_e[k].instr;
      bus.out_pc[k*WIDTH +: WIDTH]    = out_e[k].pc;
    end
    bus.in_ready  = ready;
    bus.out_avail = OW'(avail);
    bus.count     = count_q;
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      head    <= head + PW'(head_adv);
      tail    <= tail + PW'(store_n);
      count_q <= CW'(32'(count_q) + enq_n - take);
    end
  end

  // Storage needs no reset: only slots below count are ever observed
  always_ff @(posedge CLK) begin
    if (!bus.flush) begin
      for (int unsigned j = 0; j < NIN; j++) begin
        if (j < store_n) mem[wr_idx[j]] <= wr_data[j];
      end
    end
  end

endmodule
